// File: rtl/button_debouncer_pkg.sv
// Shared constants and arbitration helpers for the keypad button debouncer.
package button_debouncer_pkg;

    // Timing basis shared with the lock FSM and its clock divider.
    localparam int unsigned CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;

    // Default stability window derived from the clock: 10 ms at 100 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned CNT_W_DEF           = 20;

    // Outcome of arbitrating the two press qualifiers on one edge.
    typedef enum logic [1:0] {
        ArbNone,
        ArbZero,
        ArbOne,
        ArbCollide
    } arb_e;

    function automatic arb_e arb_decode(input logic press_zero, input logic press_one);
        arb_e res;
        unique case ({press_zero, press_one})
            2'b10:   res = ArbZero;
            2'b01:   res = ArbOne;
            2'b11:   res = ArbCollide;
            default: res = ArbNone;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Raw button inputs and conditioned outputs between the pins and the lock FSM.
interface button_debouncer_if;

    logic zero_raw;
    logic one_raw;
    logic level_zero;
    logic level_one;
    logic pulse_zero;
    logic pulse_one;
    logic collision;

    // Side that drives the raw buttons and consumes the clean signals.
    modport master (
        output zero_raw,
        output one_raw,
        input  level_zero,
        input  level_one,
        input  pulse_zero,
        input  pulse_one,
        input  collision
    );

    // The debouncer itself.
    modport slave (
        input  zero_raw,
        input  one_raw,
        output level_zero,
        output level_one,
        output pulse_zero,
        output pulse_one,
        output collision
    );

endinterface

// File: rtl/button_debouncer_channel.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level
// flop and a combinational press qualifier that fires on the rising toggle.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk_100Mhz,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             expire;

    assign expire = (sync_q != level_q) && (cnt_q == CntMax);

    // Count consecutive cycles of disagreement; flip the level when the window expires.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (expire) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchronizer, counter and level state with synchronous active-low reset.
    always_ff @(posedge clk_100Mhz) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    // Qualified only on a 0->1 toggle, so it registers downstream alongside the level.
    assign press = expire & ~level_q;

endmodule

// File: rtl/button_debouncer.sv
// Keypad front end: two debounce channels plus registered press arbitration so
// the lock FSM never sees both press pulses in the same cycle.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic                clk_100Mhz,
    input  logic                reset,
    button_debouncer_if.slave   btn
);

    logic level_zero;
    logic level_one;
    logic press_zero;
    logic press_one;
    arb_e arb;

    logic pulse_zero_q, pulse_zero_d;
    logic pulse_one_q,  pulse_one_d;
    logic collision_q,  collision_d;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_zero (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .raw        (btn.zero_raw),
        .level      (level_zero),
        .press      (press_zero)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_one (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .raw        (btn.one_raw),
        .level      (level_one),
        .press      (press_one)
    );

    assign arb = arb_decode(press_zero, press_one);

    // Map the arbitration outcome onto the one-hot pulse/collision outputs.
    always_comb begin
        pulse_zero_d = 1'b0;
        pulse_one_d  = 1'b0;
        collision_d  = 1'b0;
        unique case (arb)
            ArbZero:    pulse_zero_d = 1'b1;
            ArbOne:     pulse_one_d  = 1'b1;
            ArbCollide: collision_d  = 1'b1;
            default:    ;
        endcase
    end

    // Output registers; reset on an expiry edge suppresses the pulse.
    always_ff @(posedge clk_100Mhz) begin
        if (!reset) begin
            pulse_zero_q <= 1'b0;
            pulse_one_q  <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            pulse_zero_q <= pulse_zero_d;
            pulse_one_q  <= pulse_one_d;
            collision_q  <= collision_d;
        end
    end

    assign btn.level_zero = level_zero;
    assign btn.level_one  = level_one;
    assign btn.pulse_zero = pulse_zero_q;
    assign btn.pulse_one  = pulse_one_q;
    assign btn.collision  = collision_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4. Expected output
// snapshots are queued as stimulus is issued; a monitor compares on each cycle.
module tb_button_debouncer;

    typedef struct {
        int         edge_n;
        logic [4:0] v;      // {level_zero, level_one, pulse_zero, pulse_one, collision}
    } exp_t;

    localparam int NumEdges = 165;

    logic clk_100Mhz;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    button_debouncer_if bus ();

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .btn        (bus)
    );

    initial begin
        clk_100Mhz = 1'b0;
        forever #5 clk_100Mhz = ~clk_100Mhz;
    end

    // Edge numbering: the first rising edge is edge 1.
    initial cyc = 0;
    always @(posedge clk_100Mhz) cyc <= cyc + 1;

    task automatic expect_at(input int edge_n, input logic [4:0] v);
        exp_t e;
        e.edge_n = edge_n;
        e.v      = v;
        exp_q.push_back(e);
    endtask

    function automatic logic zero_at(input int e);
        return (e >= 10 && e <= 59) || (e >= 70 && e <= 89) ||
               (e >= 100 && e <= 111) || (e >= 120 && e <= 127);
    endfunction

    function automatic logic one_at(input int e);
        // Bounce: high 3 / low 1 over edges 24..39, then steady high from 40.
        return (e >= 24 && e <= 39 && ((e - 24) % 4 != 3)) || (e >= 40 && e <= 79) ||
               (e >= 100 && e <= 111) || (e >= 121);
    endfunction

    // Monitor: compare the queued snapshot for this edge, otherwise require no pulses.
    always @(negedge clk_100Mhz) begin
        logic [4:0] act;
        act = {bus.level_zero, bus.level_one, bus.pulse_zero, bus.pulse_one, bus.collision};
        if (cyc > 0) begin
            if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks = n_checks + 1;
                if (act !== e.v) begin
                    n_errors = n_errors + 1;
                    $display("FAIL snapshot edge %0d: got {lz,lo,pz,po,col}=%b expected %b",
                             cyc, act, e.v);
                end
            end else begin
                n_checks = n_checks + 1;
                if (act[2:0] !== 3'b000) begin
                    n_errors = n_errors + 1;
                    $display("FAIL no_spurious_pulse edge %0d: got {pz,po,col}=%b expected 000",
                             cyc, act[2:0]);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int e = 1; e <= NumEdges; e++) begin
            // Drive the values sampled on edge e.
            reset        = !(e <= 2 || e == 133 || e == 134);
            bus.zero_raw = zero_at(e);
            bus.one_raw  = one_at(e);
            case (e)
                1: expect_at(2, 5'b00000);
                10: begin
                    expect_at(14, 5'b00000);
                    expect_at(15, 5'b10100);
                    expect_at(16, 5'b10000);
                    expect_at(30, 5'b10000);
                end
                40: begin
                    expect_at(44, 5'b10000);
                    expect_at(45, 5'b11010);
                    expect_at(46, 5'b11000);
                end
                60: begin
                    expect_at(64, 5'b11000);
                    expect_at(65, 5'b01000);
                end
                70: expect_at(75, 5'b11100);
                80: expect_at(85, 5'b10000);
                90: expect_at(95, 5'b00000);
                100: begin
                    expect_at(104, 5'b00000);
                    expect_at(105, 5'b11001);
                    expect_at(106, 5'b11000);
                end
                112: expect_at(117, 5'b00000);
                120: begin
                    expect_at(125, 5'b10100);
                    expect_at(126, 5'b11010);
                end
                133: begin
                    expect_at(133, 5'b00000);
                    expect_at(134, 5'b00000);
                end
                135: begin
                    expect_at(139, 5'b00000);
                    expect_at(140, 5'b01010);
                    expect_at(141, 5'b01000);
                    expect_at(160, 5'b01000);
                end
                default: ;
            endcase
            @(posedge clk_100Mhz);
            @(negedge clk_100Mhz);
        end
        #2;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL unchecked_snapshot edge %0d: got no sample expected %b", e.edge_n, e.v);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
